// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receive path: FSM state encodings and the
// default baud divider, which the TX stage uses as well.
package uart_rx_pkg;

    localparam int unsigned DEFAULT_CLKS_PER_BIT = 32'd105;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } rx_state_e;

    // Offset of the mid-bit sample point inside the start bit.
    function automatic int unsigned half_bit(input int unsigned clks_per_bit);
        return clks_per_bit / 32'd2;
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Byte-side interface of the UART receiver: one-entry valid/ready output plus
// status pulses. The receiver drives it through the master modport.
interface uart_rx_if;
    logic [7:0] data;
    logic       valid;
    logic       ready;
    logic       frame_err;
    logic       overrun;
    logic       rx_active;

    modport master (
        output data, valid, frame_err, overrun, rx_active,
        input  ready
    );

    modport slave (
        input  data, valid, frame_err, overrun, rx_active,
        output ready
    );
endinterface

// File: rtl/uart_rx_sync2.sv
// Two-flop synchroniser for an asynchronous single-bit input; the reset value
// is chosen so the output looks like the input's idle level.
module uart_rx_sync2 #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic CLK,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    // Two-stage resynchronisation into the CLK domain.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with mid-bit sampling, a one-entry output register with
// valid/ready handshake, and framing-error / overrun status pulses.
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic      CLK,
    input  logic      rst_n,
    input  logic      RX,
    uart_rx_if.master bus
);

    localparam int unsigned         CNT_W     = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0]    HALF_LAST = CNT_W'(half_bit(CLKS_PER_BIT) - 32'd1);
    localparam logic [CNT_W-1:0]    BIT_LAST  = CNT_W'(CLKS_PER_BIT - 32'd1);

    logic             rx_s;
    logic             can_load_s;
    rx_state_e        state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       bit_idx_q;
    logic [7:0]       shift_q;
    logic [7:0]       data_q;
    logic             valid_q;
    logic             frame_err_q;
    logic             overrun_q;
    logic             rx_active_q;

    uart_rx_sync2 #(.RST_VAL(1'b1)) u_sync (
        .CLK   (CLK),
        .rst_n (rst_n),
        .d     (RX),
        .q     (rx_s)
    );

    // A finished byte may load when the register is empty or is being drained this cycle.
    always_comb begin
        can_load_s = !valid_q || bus.ready;
    end

    // Receive FSM with bit timing, shift register, output register and status pulses.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= {CNT_W{1'b0}};
            bit_idx_q   <= 3'd0;
            shift_q     <= 8'd0;
            data_q      <= 8'd0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            rx_active_q <= 1'b0;
        end else begin
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            if (valid_q && bus.ready) begin
                valid_q <= 1'b0;
            end
            case (state_q)
                ST_IDLE: begin
                    cnt_q <= {CNT_W{1'b0}};
                    if (!rx_s) begin
                        state_q     <= ST_START;
                        rx_active_q <= 1'b1;
                    end
                end
                ST_START: begin
                    if (cnt_q == HALF_LAST) begin
                        cnt_q     <= {CNT_W{1'b0}};
                        bit_idx_q <= 3'd0;
                        if (!rx_s) begin
                            state_q <= ST_DATA;
                        end else begin
                            state_q     <= ST_IDLE;
                            rx_active_q <= 1'b0;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1'b1);
                    end
                end
                ST_DATA: begin
                    if (cnt_q == BIT_LAST) begin
                        cnt_q   <= {CNT_W{1'b0}};
                        shift_q <= {rx_s, shift_q[7:1]};
                        if (bit_idx_q == 3'd7) begin
                            state_q <= ST_STOP;
                        end else begin
                            bit_idx_q <= bit_idx_q + 3'd1;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1'b1);
                    end
                end
                ST_STOP: begin
                    if (cnt_q == BIT_LAST) begin
                        cnt_q <= {CNT_W{1'b0}};
                        if (rx_s) begin
                            if (can_load_s) begin
                                data_q  <= shift_q;
                                valid_q <= 1'b1;
                            end else begin
                                overrun_q <= 1'b1;
                            end
                            state_q     <= ST_IDLE;
                            rx_active_q <= 1'b0;
                        end else begin
                            frame_err_q <= 1'b1;
                            state_q     <= ST_BREAK;
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1'b1);
                    end
                end
                // A line held low after a bad stop bit must not look like a new start.
                ST_BREAK: begin
                    cnt_q <= {CNT_W{1'b0}};
                    if (rx_s) begin
                        state_q     <= ST_IDLE;
                        rx_active_q <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    cnt_q       <= {CNT_W{1'b0}};
                    rx_active_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.data      = data_q;
    assign bus.valid     = valid_q;
    assign bus.frame_err = frame_err_q;
    assign bus.overrun   = overrun_q;
    assign bus.rx_active = rx_active_q;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: a timestamp-based frame model checked every cycle, plus
// directed scenarios with literal expectations.
module tb_uart_rx;

    localparam int CPB  = 105;
    localparam int HALF = CPB / 2;

    logic CLK   = 1'b0;
    logic rst_n = 1'b0;
    logic RX    = 1'b1;

    uart_rx_if bus ();

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .CLK   (CLK),
        .rst_n (rst_n),
        .RX    (RX),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: the line is seen two clocks late; a frame is a set of sample
    // instants counted from the cycle the falling edge is first seen.
    logic       m_q1 = 1'b1, m_q2 = 1'b1;
    bit         m_busy = 1'b0, m_brk = 1'b0;
    int         m_t0 = 0, cyc = 0;
    logic [7:0] m_bits = 8'd0, m_data = 8'd0;
    logic       m_valid = 1'b0, m_fe = 1'b0, m_ov = 1'b0;

    initial forever begin
        @(posedge CLK or negedge rst_n);
        if (!rst_n) begin
            m_q1 = 1'b1; m_q2 = 1'b1; m_busy = 1'b0; m_brk = 1'b0;
            m_data = 8'd0; m_valid = 1'b0; m_fe = 1'b0; m_ov = 1'b0; cyc = 0;
        end else begin : step
            logic rs, v, r;
            int   k;
            cyc++;
            rs = m_q2; m_q2 = m_q1; m_q1 = RX;
            v = m_valid; r = bus.ready;
            m_fe = 1'b0; m_ov = 1'b0;
            if (v && r) m_valid = 1'b0;
            if (m_busy) begin
                k = cyc - m_t0;
                if (k == HALF) begin
                    if (rs) m_busy = 1'b0;
                end else if (k > HALF && k < HALF + 9*CPB && (k - HALF) % CPB == 0) begin
                    m_bits[3'((k - HALF) / CPB - 1)] = rs;
                end else if (k == HALF + 9*CPB) begin
                    m_busy = 1'b0;
                    if (rs) begin
                        if (!v || r) begin m_data = m_bits; m_valid = 1'b1; end
                        else m_ov = 1'b1;
                    end else begin
                        m_fe = 1'b1; m_brk = 1'b1;
                    end
                end
            end else if (m_brk) begin
                if (rs) m_brk = 1'b0;
            end else if (!rs) begin
                m_busy = 1'b1; m_t0 = cyc;
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    initial forever begin
        @(negedge CLK);
        if (chk_en) begin
            chk("data",      bus.data,           m_data);
            chk("valid",     8'(bus.valid),      8'(m_valid));
            chk("frame_err", 8'(bus.frame_err),  8'(m_fe));
            chk("overrun",   8'(bus.overrun),    8'(m_ov));
            chk("rx_active", 8'(bus.rx_active),  8'(m_busy || m_brk));
        end
    end

    // Event counters sampled on the active edge (pre-edge values).
    int         n_hs = 0, n_fe = 0, n_ov = 0;
    logic [7:0] last_data = 8'd0;
    initial forever begin
        @(posedge CLK);
        if (rst_n) begin
            if (bus.valid && bus.ready) begin n_hs++; last_data = bus.data; end
            if (bus.frame_err) n_fe++;
            if (bus.overrun)   n_ov++;
        end
    end

    task automatic send(input logic [7:0] b, input logic stop_bit, input int limit);
        logic [9:0] fr;
        fr = {stop_bit, b, 1'b0};
        for (int c = 0; c < 10*CPB && c < limit; c++) begin
            RX = fr[c / CPB];
            @(negedge CLK);
        end
    endtask

    task automatic idle(input int n);
        RX = 1'b1;
        repeat (n) @(negedge CLK);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin : main
        int hs0, fe0, ov0, n;
        bit seen, ok;
        bus.ready = 1'b0;
        repeat (3) @(negedge CLK);
        chk_en = 1'b1;
        chk("rst_data",   bus.data, 8'h00);
        chk("rst_valid",  8'(bus.valid), 8'd0);
        chk("rst_active", 8'(bus.rx_active), 8'd0);
        #2 rst_n = 1'b1;
        idle(5);

        // 1: clean 0xA5 with ready held high
        bus.ready = 1'b1;
        hs0 = n_hs; fe0 = n_fe; ov0 = n_ov;
        send(8'hA5, 1'b1, 10*CPB);
        idle(5);
        chk("t1_count", 8'(n_hs - hs0), 8'd1);
        chk("t1_data",  last_data, 8'hA5);
        chk("t1_fe",    8'(n_fe - fe0), 8'd0);
        chk("t1_ov",    8'(n_ov - ov0), 8'd0);

        // 2: 20-clock glitch rejected
        hs0 = n_hs; seen = 1'b0; ok = 1'b0;
        RX = 1'b0;
        for (n = 1; n <= 200; n++) begin
            @(negedge CLK);
            if (n == 20) RX = 1'b1;
            if (bus.rx_active) seen = 1'b1;
            if (seen && !bus.rx_active) begin ok = 1'b1; break; end
        end
        chk("t2_returned", 8'(ok && n <= HALF + 3), 8'd1);
        idle(20);
        chk("t2_novalid", 8'(n_hs - hs0), 8'd0);
        chk("t2_valid",   8'(bus.valid), 8'd0);

        // 3: bad stop bit, line then held low
        hs0 = n_hs; fe0 = n_fe;
        send(8'h3C, 1'b0, 10*CPB);
        repeat (2*CPB) @(negedge CLK);
        chk("t3_fe",     8'(n_fe - fe0), 8'd1);
        chk("t3_active", 8'(bus.rx_active), 8'd1);
        chk("t3_valid",  8'(bus.valid), 8'd0);
        RX = 1'b1; ok = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            if (!bus.rx_active) begin ok = 1'b1; break; end
        end
        chk("t3_released", 8'(ok), 8'd1);
        idle(5);

        // 4: two bytes with no consumer
        bus.ready = 1'b0; ov0 = n_ov; fe0 = n_fe;
        send(8'h11, 1'b1, 10*CPB);
        send(8'h22, 1'b1, 10*CPB);
        idle(5);
        chk("t4_valid", 8'(bus.valid), 8'd1);
        chk("t4_data",  bus.data, 8'h11);
        chk("t4_ov",    8'(n_ov - ov0), 8'd1);
        chk("t4_fe",    8'(n_fe - fe0), 8'd0);

        // 5: drain 0x11 on the exact stop-sample cycle of 0x22
        hs0 = n_hs; ov0 = n_ov;
        fork
            send(8'h22, 1'b1, 10*CPB);
            begin
                repeat (999) @(negedge CLK);
                bus.ready = 1'b1;
                @(negedge CLK);
                bus.ready = 1'b0;
            end
        join
        idle(5);
        chk("t5_valid",   8'(bus.valid), 8'd1);
        chk("t5_data",    bus.data, 8'h22);
        chk("t5_ov",      8'(n_ov - ov0), 8'd0);
        chk("t5_hs",      8'(n_hs - hs0), 8'd1);
        chk("t5_drained", last_data, 8'h11);

        // 6: reset during data bit 4, then a clean frame
        send(8'h5A, 1'b1, HALF + 5*CPB);
        #2 rst_n = 1'b0;
        RX = 1'b1;
        repeat (3) @(negedge CLK);
        chk("t6_data",   bus.data, 8'h00);
        chk("t6_valid",  8'(bus.valid), 8'd0);
        chk("t6_fe",     8'(bus.frame_err), 8'd0);
        chk("t6_ov",     8'(bus.overrun), 8'd0);
        chk("t6_active", 8'(bus.rx_active), 8'd0);
        #2 rst_n = 1'b1;
        idle(5);
        bus.ready = 1'b1; hs0 = n_hs;
        send(8'hC3, 1'b1, 10*CPB);
        idle(5);
        chk("t6_count", 8'(n_hs - hs0), 8'd1);
        chk("t6_next",  last_data, 8'hC3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
